// File: rtl/tone_player.sv
// Square-wave tone generator fed by the key decoder's note period.
// A release-hold window bridges the brief zero gaps in PS/2 break sequences.
//   state | meaning
//   IDLE  | silent, waiting for a valid period
//   PLAY  | toggling speaker at cur_period, input valid
//   HOLD  | input went invalid, still sounding until the hold window expires
module tone_player #(
    parameter int PERIOD_W    = 18,
    parameter int HOLD_CYCLES = 2500000,
    parameter int MIN_PERIOD  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                enable,
    output logic                speaker,
    output logic                active,
    output logic [PERIOD_W-1:0] cur_period
);

    localparam int PH_W   = PERIOD_W - 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [PH_W-1:0]     phase_cnt, phase_nx, half_m1;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx;
    logic [PERIOD_W-1:0] period_nx;
    logic                speaker_nx;
    logic                valid, same, wrap;

    assign valid   = (period_in >= MIN_P);
    assign same    = (period_in == cur_period);
    // Half period drops the LSB, so an odd period plays one cycle short.
    assign half_m1 = cur_period[PERIOD_W-1:1] - PH_W'(1);
    assign wrap    = (phase_cnt == half_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            speaker    <= 1'b0;
            active     <= 1'b0;
            cur_period <= '0;
            phase_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nx;
            speaker    <= speaker_nx;
            active     <= (state_nx != IDLE);
            cur_period <= period_nx;
            phase_cnt  <= phase_nx;
            hold_cnt   <= hold_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        period_nx  = cur_period;
        hold_nx    = hold_cnt;
        phase_nx   = wrap ? '0 : phase_cnt + PH_W'(1);
        speaker_nx = wrap ? ~speaker : speaker;

        if (!enable) begin
            state_nx   = IDLE;
            period_nx  = '0;
            phase_nx   = '0;
            hold_nx    = '0;
            speaker_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    period_nx  = '0;
                    phase_nx   = '0;
                    hold_nx    = '0;
                    speaker_nx = 1'b0;
                    if (valid) begin
                        state_nx  = PLAY;
                        period_nx = period_in;
                    end
                end
                PLAY: begin
                    if (valid && !same) begin
                        period_nx  = period_in;
                        phase_nx   = '0;
                        speaker_nx = 1'b0;
                    end else if (!valid) begin
                        state_nx = HOLD;
                        hold_nx  = '0;
                    end
                end
                HOLD: begin
                    // A valid sample outranks hold expiry on the same edge.
                    if (valid) begin
                        state_nx = PLAY;
                        hold_nx  = '0;
                        if (!same) begin
                            period_nx  = period_in;
                            phase_nx   = '0;
                            speaker_nx = 1'b0;
                        end
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nx   = IDLE;
                        period_nx  = '0;
                        phase_nx   = '0;
                        hold_nx    = '0;
                        speaker_nx = 1'b0;
                    end else begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    period_nx  = '0;
                    phase_nx   = '0;
                    hold_nx    = '0;
                    speaker_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with a 100-cycle hold window and MIN_PERIOD of 4.
// Expected speaker level after the k-th edge since a (re)start is (k / half) % 2.
module tb_tone_player;

    localparam int PW = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [PW-1:0] period_in = '0;
    logic          speaker;
    logic          active;
    logic [PW-1:0] cur_period;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_player #(
        .PERIOD_W   (PW),
        .HOLD_CYCLES(100),
        .MIN_PERIOD (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .period_in (period_in),
        .enable    (enable),
        .speaker   (speaker),
        .active    (active),
        .cur_period(cur_period)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_dut();
        reset     = 1'b1;
        enable    = 1'b1;
        period_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_tone(input string tag, input int k, input int half, input int per);
        check_eq({tag, "_spk"}, 32'(speaker), 32'((k / half) % 2));
        check_eq({tag, "_act"}, 32'(active), 32'd1);
        check_eq({tag, "_per"}, 32'(cur_period), 32'(per));
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, "_spk"}, 32'(speaker), 32'd0);
        check_eq({tag, "_act"}, 32'(active), 32'd0);
        check_eq({tag, "_per"}, 32'(cur_period), 32'd0);
    endtask

    initial begin
        // reset state, then steady tone at period 10
        restart_dut();
        expect_idle("reset");
        period_in = 10;
        for (int k = 0; k < 100; k++) begin
            tick();
            expect_tone("t1_steady", k, 5, 10);
        end

        // short zero gap must not disturb the phase
        for (int k = 100; k < 160; k++) begin
            tick();
            expect_tone("t2_pre", k, 5, 10);
        end
        period_in = 0;
        for (int k = 160; k < 180; k++) begin
            tick();
            expect_tone("t2_gap", k, 5, 10);
        end
        period_in = 10;
        for (int k = 180; k < 210; k++) begin
            tick();
            expect_tone("t2_post", k, 5, 10);
        end

        // release: a fresh hold window sounds exactly 100 more edges
        period_in = 0;
        for (int k = 210; k < 310; k++) begin
            tick();
            expect_tone("t3_hold", k, 5, 10);
        end
        tick();
        expect_idle("t3_expire");
        for (int j = 0; j < 10; j++) begin
            tick();
            expect_idle("t3_silent");
        end

        // period change restarts phase from low
        restart_dut();
        period_in = 10;
        for (int k = 0; k < 28; k++) begin
            tick();
            expect_tone("t4_p10", k, 5, 10);
        end
        period_in = 16;
        for (int m = 0; m < 32; m++) begin
            tick();
            expect_tone("t4_p16", m, 8, 16);
        end

        // below-minimum period, minimum period, odd period
        restart_dut();
        period_in = 3;
        for (int j = 0; j < 5; j++) begin
            tick();
            expect_idle("t5_below");
        end
        period_in = 4;
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_tone("t5_min", k, 2, 4);
        end
        period_in = 11;
        for (int m = 0; m < 22; m++) begin
            tick();
            expect_tone("t5_odd", m, 5, 11);
        end

        // enable low mutes and ignores period_in
        period_in = 10;
        for (int m = 0; m < 8; m++) begin
            tick();
            expect_tone("t5_pre_mute", m, 5, 10);
        end
        enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            expect_idle("t5_mute");
        end
        enable = 1'b1;
        for (int m = 0; m < 15; m++) begin
            tick();
            expect_tone("t5_unmute", m, 5, 10);
        end

        // asynchronous reset between edges while speaker is high
        restart_dut();
        period_in = 10;
        for (int k = 0; k < 7; k++) begin
            tick();
            expect_tone("t6_pre", k, 5, 10);
        end
        check_eq("t6_high_before", 32'(speaker), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        expect_idle("t6_async");
        #1;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            expect_tone("t6_post", k, 5, 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
